// File: rtl/yuv422_to_444.sv
// yuv422_to_444: 4:2:2 -> 4:4:4 chroma upsampler by pair replication.
// Two register stages: S1 captures the input beat, S2 is the output register.
// The next beat on the input port gives S2 a one-pixel lookahead, so an even
// pixel can take its second chroma from the following odd pixel.
// DE/HS/VS travel with the video so downstream timing stays aligned.
module yuv422_to_444 #(
    parameter int C_BPC      = 8,
    parameter bit C_CB_FIRST = 1'b1
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             DE_I,
    input  logic             HS_I,
    input  logic             VS_I,
    input  logic [C_BPC-1:0] Y_I,
    input  logic [C_BPC-1:0] C_I,
    output logic             DE_O,
    output logic             HS_O,
    output logic             VS_O,
    output logic [C_BPC-1:0] Y_O,
    output logic [C_BPC-1:0] U_O,
    output logic [C_BPC-1:0] V_O,
    output logic             ODD_LEN_O
);

    // Midcode substituted for the missing chroma of a line with no odd pixel.
    localparam logic [C_BPC-1:0] MIDCODE = {1'b1, {(C_BPC-1){1'b0}}};

    // Phase expected for the next input beat; 0 = even pixel.
    logic             ph_q, ph_d;

    // S1 stage: captured input beat plus its phase.
    logic             de_p1_q, hs_p1_q, vs_p1_q, ph_p1_q;
    logic [C_BPC-1:0] y_p1_q, c_p1_q;

    // Hold regs: first holds the even-pixel chroma, second the odd-pixel one.
    logic [C_BPC-1:0] first_hold_q, first_hold_d;
    logic [C_BPC-1:0] second_hold_q, second_hold_d;

    // S2 stage: output register.
    logic             de_p2_q, hs_p2_q, vs_p2_q, odd_p2_q, odd_d;
    logic [C_BPC-1:0] y_p2_q, u_p2_q, v_p2_q, u_d, v_d;

    logic             line_start;
    logic [C_BPC-1:0] first_c, second_c;

    // Next-state for phase, hold regs and the reconstructed chroma of S1's pixel.
    always_comb begin
        // A line starts on a DE-high beat that follows a DE-low beat (or reset).
        line_start = DE_I & ~de_p1_q;
        ph_d       = DE_I ? ~ph_q : 1'b0;

        first_hold_d = first_hold_q;
        if (DE_I && !ph_q) begin
            first_hold_d = C_I;
        end

        second_hold_d = second_hold_q;
        if (line_start) begin
            second_hold_d = MIDCODE;
        end else if (DE_I && ph_q) begin
            second_hold_d = C_I;
        end

        if (!ph_p1_q) begin
            // Even pixel: pair with the next beat, or fall back to the hold
            // reg (midcode if the line never had an odd pixel) at line end.
            first_c  = c_p1_q;
            second_c = DE_I ? C_I : second_hold_q;
        end else begin
            // Odd pixel: reuse the preceding even pixel's chroma.
            first_c  = first_hold_q;
            second_c = c_p1_q;
        end

        odd_d = de_p1_q & ~ph_p1_q & ~DE_I;
        u_d   = C_CB_FIRST ? first_c : second_c;
        v_d   = C_CB_FIRST ? second_c : first_c;
    end

    // Register S1, phase and hold regs; a reset discards any partial line.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ph_q          <= 1'b0;
            de_p1_q       <= 1'b0;
            hs_p1_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
            ph_p1_q       <= 1'b0;
            y_p1_q        <= '0;
            c_p1_q        <= '0;
            first_hold_q  <= '0;
            second_hold_q <= '0;
        end else begin
            ph_q          <= ph_d;
            de_p1_q       <= DE_I;
            hs_p1_q       <= HS_I;
            vs_p1_q       <= VS_I;
            ph_p1_q       <= DE_I & ph_q;
            y_p1_q        <= Y_I;
            c_p1_q        <= C_I;
            first_hold_q  <= first_hold_d;
            second_hold_q <= second_hold_d;
        end
    end

    // Register S2, the output stage.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            de_p2_q  <= 1'b0;
            hs_p2_q  <= 1'b0;
            vs_p2_q  <= 1'b0;
            odd_p2_q <= 1'b0;
            y_p2_q   <= '0;
            u_p2_q   <= '0;
            v_p2_q   <= '0;
        end else begin
            de_p2_q  <= de_p1_q;
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
            odd_p2_q <= odd_d;
            y_p2_q   <= y_p1_q;
            u_p2_q   <= u_d;
            v_p2_q   <= v_d;
        end
    end

    assign DE_O      = de_p2_q;
    assign HS_O      = hs_p2_q;
    assign VS_O      = vs_p2_q;
    assign Y_O       = y_p2_q;
    assign U_O       = u_p2_q;
    assign V_O       = v_p2_q;
    assign ODD_LEN_O = odd_p2_q;

endmodule

// File: tb/tb_yuv422_to_444.sv
// tb_yuv422_to_444: directed bench for the 4:2:2 -> 4:4:4 upsampler.
// dut_a: 8-bit, Cb first. dut_b: 10-bit, Cr first. dut_c: 10-bit, Cb first.
module tb_yuv422_to_444;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       de_a = 1'b0, hs_a = 1'b0, vs_a = 1'b0;
    logic [7:0] y_a = '0, c_a = '0;
    logic       de_ao, hs_ao, vs_ao, odd_ao;
    logic [7:0] y_ao, u_ao, v_ao;

    logic       de_b = 1'b0, hs_b = 1'b0, vs_b = 1'b0;
    logic [9:0] y_b = '0, c_b = '0;
    logic       de_bo, hs_bo, vs_bo, odd_bo;
    logic [9:0] y_bo, u_bo, v_bo;
    logic       de_co, hs_co, vs_co, odd_co;
    logic [9:0] y_co, u_co, v_co;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yuv422_to_444 #(.C_BPC(8), .C_CB_FIRST(1'b1)) dut_a (
        .CLK_I(clk), .RST_I(rst_n), .DE_I(de_a), .HS_I(hs_a), .VS_I(vs_a),
        .Y_I(y_a), .C_I(c_a), .DE_O(de_ao), .HS_O(hs_ao), .VS_O(vs_ao),
        .Y_O(y_ao), .U_O(u_ao), .V_O(v_ao), .ODD_LEN_O(odd_ao)
    );

    yuv422_to_444 #(.C_BPC(10), .C_CB_FIRST(1'b0)) dut_b (
        .CLK_I(clk), .RST_I(rst_n), .DE_I(de_b), .HS_I(hs_b), .VS_I(vs_b),
        .Y_I(y_b), .C_I(c_b), .DE_O(de_bo), .HS_O(hs_bo), .VS_O(vs_bo),
        .Y_O(y_bo), .U_O(u_bo), .V_O(v_bo), .ODD_LEN_O(odd_bo)
    );

    yuv422_to_444 #(.C_BPC(10), .C_CB_FIRST(1'b1)) dut_c (
        .CLK_I(clk), .RST_I(rst_n), .DE_I(de_b), .HS_I(hs_b), .VS_I(vs_b),
        .Y_I(y_b), .C_I(c_b), .DE_O(de_co), .HS_O(hs_co), .VS_O(vs_co),
        .Y_O(y_co), .U_O(u_co), .V_O(v_co), .ODD_LEN_O(odd_co)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check one valid output pixel of dut_a.
    task automatic px_a(input string tag, input int y, input int u, input int v, input logic odd);
        chk({tag, ".de"}, {31'd0, de_ao}, 32'd1);
        chk({tag, ".y"}, {24'd0, y_ao}, y);
        chk({tag, ".u"}, {24'd0, u_ao}, u);
        chk({tag, ".v"}, {24'd0, v_ao}, v);
        chk({tag, ".odd"}, {31'd0, odd_ao}, {31'd0, odd});
    endtask

    // Apply one beat to dut_a just after a rising edge; dut_b/c idle.
    task automatic beat_a(input logic de, input logic hs, input logic vs,
                          input logic [7:0] y, input logic [7:0] c);
        @(posedge clk);
        #1;
        de_a = de; hs_a = hs; vs_a = vs; y_a = y; c_a = c;
        de_b = 1'b0;
    endtask

    // Apply one beat to dut_b/dut_c; dut_a idle.
    task automatic beat_b(input logic de, input logic [9:0] y, input logic [9:0] c);
        @(posedge clk);
        #1;
        de_b = de; y_b = y; c_b = c;
        de_a = 1'b0;
    endtask

    initial begin
        // T1: reset held with DE toggling -> outputs stay 0.
        beat_a(1, 1, 1, 8'd5, 8'd9);
        beat_a(0, 0, 0, 8'd6, 8'd8);
        beat_a(1, 1, 1, 8'd7, 8'd7);
        chk("rst.de", {31'd0, de_ao}, 32'd0);
        chk("rst.hs", {31'd0, hs_ao}, 32'd0);
        chk("rst.vs", {31'd0, vs_ao}, 32'd0);
        chk("rst.y", {24'd0, y_ao}, 32'd0);
        chk("rst.u", {24'd0, u_ao}, 32'd0);
        chk("rst.v", {24'd0, v_ao}, 32'd0);
        chk("rst.odd", {31'd0, odd_ao}, 32'd0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        chk("rst.de2", {31'd0, de_ao}, 32'd0);
        #2 rst_n = 1'b1;
        beat_a(0, 0, 0, 8'd0, 8'd0);

        // T2: 4-px line, HS on px0 and VS on px1.
        beat_a(1, 1, 0, 8'd10, 8'd100);
        beat_a(1, 0, 1, 8'd20, 8'd200);
        chk("lat.de_early", {31'd0, de_ao}, 32'd0);
        beat_a(1, 0, 0, 8'd30, 8'd110);
        px_a("t2.p0", 10, 100, 200, 1'b0);
        chk("t2.hs", {31'd0, hs_ao}, 32'd1);
        chk("t2.vs0", {31'd0, vs_ao}, 32'd0);
        beat_a(1, 0, 0, 8'd40, 8'd210);
        px_a("t2.p1", 20, 100, 200, 1'b0);
        chk("t2.vs", {31'd0, vs_ao}, 32'd1);
        chk("t2.hs0", {31'd0, hs_ao}, 32'd0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t2.p2", 30, 110, 210, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t2.p3", 40, 110, 210, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        chk("t2.end_de", {31'd0, de_ao}, 32'd0);

        // T3: 3-px line, then a 1-px line.
        beat_a(1, 0, 0, 8'd1, 8'd100);
        beat_a(1, 0, 0, 8'd2, 8'd200);
        beat_a(1, 0, 0, 8'd3, 8'd110);
        px_a("t3.p0", 1, 100, 200, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t3.p1", 2, 100, 200, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t3.p2", 3, 110, 200, 1'b1);
        beat_a(1, 0, 0, 8'd9, 8'd77);
        chk("t3.odd_pulse", {31'd0, odd_ao}, 32'd0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t3.one", 9, 77, 128, 1'b1);

        // T4: back-to-back lines separated by a single DE-low beat.
        beat_a(1, 0, 0, 8'd11, 8'd50);
        beat_a(1, 0, 0, 8'd12, 8'd60);
        beat_a(1, 0, 0, 8'd13, 8'd55);
        px_a("t4.a0", 11, 50, 60, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t4.a1", 12, 50, 60, 1'b0);
        beat_a(1, 0, 0, 8'd21, 8'd70);
        px_a("t4.a2", 13, 55, 60, 1'b1);
        beat_a(1, 0, 0, 8'd22, 8'd80);
        chk("t4.gap_de", {31'd0, de_ao}, 32'd0);
        chk("t4.gap_odd", {31'd0, odd_ao}, 32'd0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t4.b0", 21, 70, 80, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t4.b1", 22, 70, 80, 1'b0);

        // T5: Cr-first 10-bit pair, then 10-bit 1-px lines.
        beat_b(1, 10'd5, 10'd200);
        beat_b(1, 10'd6, 10'd100);
        beat_b(0, 10'd0, 10'd0);
        chk("t5.b0.de", {31'd0, de_bo}, 32'd1);
        chk("t5.b0.u", {22'd0, u_bo}, 32'd100);
        chk("t5.b0.v", {22'd0, v_bo}, 32'd200);
        chk("t5.c0.u", {22'd0, u_co}, 32'd200);
        chk("t5.c0.v", {22'd0, v_co}, 32'd100);
        beat_b(0, 10'd0, 10'd0);
        chk("t5.b1.y", {22'd0, y_bo}, 32'd6);
        chk("t5.b1.u", {22'd0, u_bo}, 32'd100);
        chk("t5.b1.v", {22'd0, v_bo}, 32'd200);
        chk("t5.b1.odd", {31'd0, odd_bo}, 32'd0);
        beat_b(1, 10'd7, 10'd300);
        beat_b(0, 10'd0, 10'd0);
        beat_b(0, 10'd0, 10'd0);
        chk("t5.c1px.u", {22'd0, u_co}, 32'd300);
        chk("t5.c1px.v", {22'd0, v_co}, 32'd512);
        chk("t5.c1px.odd", {31'd0, odd_co}, 32'd1);
        chk("t5.b1px.u", {22'd0, u_bo}, 32'd512);
        chk("t5.b1px.v", {22'd0, v_bo}, 32'd300);

        // T6: reset pulse after 5 px of an 8-px line.
        beat_a(1, 0, 0, 8'd1, 8'd10);
        beat_a(1, 0, 0, 8'd2, 8'd20);
        beat_a(1, 0, 0, 8'd3, 8'd30);
        px_a("t6.p0", 1, 10, 20, 1'b0);
        beat_a(1, 0, 0, 8'd4, 8'd40);
        px_a("t6.p1", 2, 10, 20, 1'b0);
        beat_a(1, 0, 0, 8'd5, 8'd50);
        px_a("t6.p2", 3, 30, 40, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.de", {31'd0, de_ao}, 32'd0);
        chk("t6.rst.y", {24'd0, y_ao}, 32'd0);
        chk("t6.rst.u", {24'd0, u_ao}, 32'd0);
        chk("t6.rst.v", {24'd0, v_ao}, 32'd0);
        chk("t6.rst.odd", {31'd0, odd_ao}, 32'd0);
        de_a = 1'b1; y_a = 8'd6; c_a = 8'd60;
        #2 rst_n = 1'b1;
        beat_a(1, 0, 0, 8'd7, 8'd70);
        chk("t6.rel.de", {31'd0, de_ao}, 32'd0);
        beat_a(1, 0, 0, 8'd8, 8'd80);
        px_a("t6.p5", 6, 60, 70, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t6.p6", 7, 60, 70, 1'b0);
        beat_a(0, 0, 0, 8'd0, 8'd0);
        px_a("t6.p7", 8, 80, 70, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
